// File: rtl/hdmi_text_console_writer_if.sv
// -----------------------------------------------------------------------------
// hdmi_text_console_writer_if
// AXI4-Lite write-only bus between the console writer (master) and the text
// controller VRAM (slave).
//   awaddr/awprot/awvalid/awready : write-address channel
//   wdata/wstrb/wvalid/wready     : write-data channel (32-bit data only)
//   bresp/bvalid/bready           : write-response channel
// -----------------------------------------------------------------------------
interface hdmi_text_console_writer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/hdmi_text_console_writer.sv
// -----------------------------------------------------------------------------
// hdmi_text_console_writer
// Accepts character codes and writes each printable one into the text
// controller's VRAM through a single-outstanding AXI4-Lite write, keeping a
// row/col cursor. 0x0A = line feed, 0x0D = carriage return.
// Optional feature macro: HDMI_CONSOLE_CLEAR_EN -- 0x0C clears the whole screen
// (COLS*ROWS/4 word writes of zero) and homes the cursor; without it 0x0C is
// printable.
// Ports:
//   axi_aclk, axi_aresetn       : clock, async-assert active-low reset
//   s_char_data/valid/ready     : character input handshake
//   m_axi                       : AXI4-Lite master (write channels only)
//   cursor                      : linear index row*COLS+col
//   busy                        : FSM not idle
//   resp_err                    : sticky, set by any non-OKAY bresp
// -----------------------------------------------------------------------------
module hdmi_text_console_writer #(
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int VRAM_BASE        = 0,
    parameter int COLS             = 80,
    parameter int ROWS             = 30
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,
    input  logic [7:0]                  s_char_data,
    input  logic                        s_char_valid,
    output logic                        s_char_ready,
    hdmi_text_console_writer_if.master  m_axi,
    output logic [11:0]                 cursor,
    output logic                        busy,
    output logic                        resp_err
);

    localparam logic [C_AXI_ADDR_WIDTH-1:0] BASE_C = C_AXI_ADDR_WIDTH'(VRAM_BASE);
    localparam logic [11:0] COLS_C    = 12'(COLS);
    localparam logic [11:0] COLS_M1_C = 12'(COLS - 1);
    localparam logic [11:0] ROWS_M1_C = 12'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RESP  = 2'd2
`ifdef HDMI_CONSOLE_CLEAR_EN
        ,
        CLEAR = 2'd3
`endif
    } state_t;

    state_t                        state_q, state_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic [C_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [C_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]                    wstrb_q, wstrb_d;
    logic [11:0]                   row_q, row_d;
    logic [11:0]                   col_q, col_d;
    logic [11:0]                   cur_q, cur_d;
    logic                          err_q, err_d;
    logic [11:0]                   adv_row_s, adv_col_s, adv_cur_s;
`ifdef HDMI_CONSOLE_CLEAR_EN
    localparam logic [9:0] CLR_LAST_C = 10'(COLS * ROWS / 4 - 1);
    logic                          clr_act_q, clr_act_d;
    logic [9:0]                    clr_idx_q, clr_idx_d;
`endif

    // Cursor position after one printed cell: next column, next row, or wrap home.
    always_comb begin
        adv_col_s = col_q + 12'd1;
        adv_row_s = row_q;
        adv_cur_s = cur_q + 12'd1;
        if (col_q == COLS_M1_C) begin
            adv_col_s = 12'd0;
            if (row_q == ROWS_M1_C) begin
                adv_row_s = 12'd0;
                adv_cur_s = 12'd0;
            end else begin
                adv_row_s = row_q + 12'd1;
            end
        end else begin
            adv_col_s = col_q + 12'd1;
        end
    end

    // Next-state and next-output logic of the write FSM.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        row_d     = row_q;
        col_d     = col_q;
        cur_d     = cur_q;
        err_d     = err_q;
`ifdef HDMI_CONSOLE_CLEAR_EN
        clr_act_d = clr_act_q;
        clr_idx_d = clr_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_char_valid) begin
                    if (s_char_data == 8'h0A) begin
                        // Line feed: linear index moves back to column 0 then down one row.
                        col_d = 12'd0;
                        if (row_q == ROWS_M1_C) begin
                            row_d = 12'd0;
                            cur_d = 12'd0;
                        end else begin
                            row_d = row_q + 12'd1;
                            cur_d = cur_q - col_q + COLS_C;
                        end
                    end else if (s_char_data == 8'h0D) begin
                        col_d = 12'd0;
                        cur_d = cur_q - col_q;
`ifdef HDMI_CONSOLE_CLEAR_EN
                    end else if (s_char_data == 8'h0C) begin
                        clr_act_d = 1'b1;
                        clr_idx_d = 10'd0;
                        state_d   = CLEAR;
`endif
                    end else begin
                        // Word-aligned address, byte lane selected by the low cursor bits.
                        awaddr_d  = BASE_C + C_AXI_ADDR_WIDTH'({cur_q[11:2], 2'b00});
                        wdata_d   = {4{s_char_data}};
                        wstrb_d   = 4'b0001 << cur_q[1:0];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = XFER;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                // Each channel retires on its own handshake edge.
                awvalid_d = awvalid_q & ~m_axi.awready;
                wvalid_d  = wvalid_q & ~m_axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = RESP;
                end else begin
                    state_d = XFER;
                end
            end
            RESP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
`ifdef HDMI_CONSOLE_CLEAR_EN
                    if (clr_act_q) begin
                        if (clr_idx_q == CLR_LAST_C) begin
                            clr_act_d = 1'b0;
                            row_d     = 12'd0;
                            col_d     = 12'd0;
                            cur_d     = 12'd0;
                            state_d   = IDLE;
                        end else begin
                            clr_idx_d = clr_idx_q + 10'd1;
                            state_d   = CLEAR;
                        end
                    end else begin
`endif
                        row_d   = adv_row_s;
                        col_d   = adv_col_s;
                        cur_d   = adv_cur_s;
                        state_d = IDLE;
`ifdef HDMI_CONSOLE_CLEAR_EN
                    end
`endif
                end else begin
                    state_d = RESP;
                end
            end
`ifdef HDMI_CONSOLE_CLEAR_EN
            CLEAR: begin
                // One zero word per clear step, full strobe.
                awaddr_d  = BASE_C + C_AXI_ADDR_WIDTH'({clr_idx_q, 2'b00});
                wdata_d   = '0;
                wstrb_d   = 4'hF;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = XFER;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'h0;
            row_q     <= 12'd0;
            col_q     <= 12'd0;
            cur_q     <= 12'd0;
            err_q     <= 1'b0;
`ifdef HDMI_CONSOLE_CLEAR_EN
            clr_act_q <= 1'b0;
            clr_idx_q <= 10'd0;
`endif
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cur_q     <= cur_d;
            err_q     <= err_d;
`ifdef HDMI_CONSOLE_CLEAR_EN
            clr_act_q <= clr_act_d;
            clr_idx_q <= clr_idx_d;
`endif
        end
    end

    assign s_char_ready  = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign cursor        = cur_q;
    assign resp_err      = err_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = (state_q == RESP);

endmodule

// File: tb/tb_hdmi_text_console_writer.sv
// -----------------------------------------------------------------------------
// Bench for hdmi_text_console_writer: a behavioural screen model predicts every
// VRAM write (pushed into a queue on character acceptance) and the cursor; an
// AXI slave/monitor process pops and compares each completed write.
// -----------------------------------------------------------------------------
module tb_hdmi_text_console_writer;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int NCELL = COLS * ROWS;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk;
    logic        axi_aresetn;
    logic [7:0]  s_char_data;
    logic        s_char_valid;
    logic        s_char_ready;
    logic [11:0] cursor;
    logic        busy;
    logic        resp_err;

    hdmi_text_console_writer_if #(.ADDR_WIDTH(16)) axi ();

    hdmi_text_console_writer dut (
        .axi_aclk     (clk),
        .axi_aresetn  (axi_aresetn),
        .s_char_data  (s_char_data),
        .s_char_valid (s_char_valid),
        .s_char_ready (s_char_ready),
        .m_axi        (axi),
        .cursor       (cursor),
        .busy         (busy),
        .resp_err     (resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          mode   = 0;     // 0 readys high, 1 random, 2 wready 3 late, 3 readys low
    logic [1:0]  bresp_sel = 2'b00;
    logic        exp_err = 1'b0;
    int          exp_row = 0;
    int          exp_col = 0;
    int          writes_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // Screen model: what each accepted character should do.
    task automatic model_accept(input logic [7:0] c);
        int  lin;
        wr_t w;
        lin = exp_row * COLS + exp_col;
        if (c == 8'h0A) begin
            exp_col = 0;
            exp_row = (exp_row + 1) % ROWS;
        end else if (c == 8'h0D) begin
            exp_col = 0;
`ifdef HDMI_CONSOLE_CLEAR_EN
        end else if (c == 8'h0C) begin
            for (int k = 0; k < NCELL / 4; k++) begin
                w.addr = 16'(4 * k);
                w.data = 32'h0;
                w.strb = 4'hF;
                exp_q.push_back(w);
            end
            exp_row = 0;
            exp_col = 0;
`endif
        end else begin
            w.addr = 16'(lin - (lin % 4));
            w.data = {c, c, c, c};
            w.strb = 4'(1 << (lin % 4));
            exp_q.push_back(w);
            exp_col = exp_col + 1;
            if (exp_col == COLS) begin
                exp_col = 0;
                exp_row = (exp_row + 1) % ROWS;
            end
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        s_char_data  = c;
        s_char_valid = 1'b1;
        while (!s_char_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            timeout_fail("send_char");
        end else begin
            model_accept(c);
        end
        @(negedge clk);
        s_char_valid = 1'b0;
    endtask

    task automatic wait_check(input string name);
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            timeout_fail(name);
        end else begin
            chk({name, "_cursor"}, 32'(cursor), 32'(exp_row * COLS + exp_col));
            chk({name, "_resp_err"}, 32'(resp_err), 32'(exp_err));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 axi_aresetn = 1'b0;
        exp_q.delete();
        exp_row = 0;
        exp_col = 0;
        exp_err = 1'b0;
        #1;
        chk("rst_awvalid", 32'(axi.awvalid), 32'h0);
        chk("rst_wvalid", 32'(axi.wvalid), 32'h0);
        chk("rst_bready", 32'(axi.bready), 32'h0);
        chk("rst_cursor", 32'(cursor), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_awaddr", 32'(axi.awaddr), 32'h0);
        chk("rst_wdata", axi.wdata, 32'h0);
        chk("rst_wstrb", 32'(axi.wstrb), 32'h0);
        @(negedge clk);
        #3 axi_aresetn = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(s_char_ready), 32'h1);
        chk("rel_busy", 32'(busy), 32'h0);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 126));
    endfunction

    // AXI slave responder plus monitor: pops the expected queue on every write.
    initial begin : slave_monitor
        logic aw_got, w_got, pend_b;
        logic aw_hs, w_hs, aw_hs_prev, w_hs_prev, order_prev;
        logic aw_stall_prev, w_stall_prev;
        logic [15:0] aw_addr_prev, cap_addr;
        logic [31:0] w_data_prev, cap_data;
        logic [3:0]  w_strb_prev, cap_strb;
        int w_wait;
        wr_t e;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        aw_got = 1'b0; w_got = 1'b0; pend_b = 1'b0;
        aw_hs_prev = 1'b0; w_hs_prev = 1'b0; order_prev = 1'b0;
        aw_stall_prev = 1'b0; w_stall_prev = 1'b0;
        aw_addr_prev = 16'h0; w_data_prev = 32'h0; w_strb_prev = 4'h0;
        cap_addr = 16'h0; cap_data = 32'h0; cap_strb = 4'h0;
        w_wait = 0;
        forever begin
            @(negedge clk);
            if (!axi_aresetn) begin
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                axi.bvalid  = 1'b0;
                aw_got = 1'b0; w_got = 1'b0; pend_b = 1'b0;
                aw_hs_prev = 1'b0; w_hs_prev = 1'b0; order_prev = 1'b0;
                aw_stall_prev = 1'b0; w_stall_prev = 1'b0;
                w_wait = 0;
            end else begin
                if (aw_hs_prev) chk("awvalid_drop", 32'(axi.awvalid), 32'h0);
                if (w_hs_prev) chk("wvalid_drop", 32'(axi.wvalid), 32'h0);
                if (order_prev) chk("wvalid_after_aw", 32'(axi.wvalid), 32'h1);
                if (aw_stall_prev) begin
                    chk("aw_hold", 32'(axi.awvalid), 32'h1);
                    chk("awaddr_hold", 32'(axi.awaddr), 32'(aw_addr_prev));
                end
                if (w_stall_prev) begin
                    chk("w_hold", 32'(axi.wvalid), 32'h1);
                    chk("wdata_hold", axi.wdata, w_data_prev);
                    chk("wstrb_hold", 32'(axi.wstrb), 32'(w_strb_prev));
                end
                if (axi.bready) chk("bready_excl", 32'({axi.awvalid, axi.wvalid}), 32'h0);

                // Response channel; occasional stray bvalid while no write pending.
                axi.bvalid = pend_b || (mode == 1 && $urandom_range(0, 7) == 0);
                axi.bresp  = pend_b ? bresp_sel : 2'b11;
                if (axi.bvalid && axi.bready) begin
                    chk("b_expected", 32'(pend_b), 32'h1);
                    if (pend_b && bresp_sel != 2'b00) exp_err = 1'b1;
                    pend_b = 1'b0;
                end

                case (mode)
                    0: begin axi.awready = 1'b1; axi.wready = 1'b1; end
                    1: begin
                        axi.awready = 1'($urandom_range(0, 1));
                        axi.wready  = 1'($urandom_range(0, 1));
                    end
                    2: begin axi.awready = 1'b1; axi.wready = (w_wait >= 3); end
                    default: begin axi.awready = 1'b0; axi.wready = 1'b0; end
                endcase
                if (axi.wvalid && !axi.wready) w_wait++;
                else w_wait = 0;

                aw_hs = axi.awvalid && axi.awready;
                w_hs  = axi.wvalid && axi.wready;
                order_prev = 1'b0;
                if (aw_hs) begin
                    chk("one_outstanding", 32'({aw_got, pend_b}), 32'h0);
                    chk("awprot", 32'(axi.awprot), 32'h0);
                    aw_got = 1'b1;
                    cap_addr = axi.awaddr;
                    order_prev = (mode == 2);
                end
                if (w_hs) begin
                    w_got = 1'b1;
                    cap_data = axi.wdata;
                    cap_strb = axi.wstrb;
                end
                if (aw_got && w_got) begin
                    writes_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write addr=%h data=%h strb=%h", cap_addr, cap_data, cap_strb);
                    end else begin
                        e = exp_q.pop_front();
                        chk("awaddr", 32'(cap_addr), 32'(e.addr));
                        chk("wdata", cap_data, e.data);
                        chk("wstrb", 32'(cap_strb), 32'(e.strb));
                    end
                    aw_got = 1'b0;
                    w_got = 1'b0;
                    pend_b = 1'b1;
                end
                aw_hs_prev = aw_hs;
                w_hs_prev = w_hs;
                aw_stall_prev = axi.awvalid && !axi.awready;
                w_stall_prev = axi.wvalid && !axi.wready;
                aw_addr_prev = axi.awaddr;
                w_data_prev = axi.wdata;
                w_strb_prev = axi.wstrb;
            end
        end
    end

    // Main stimulus sequence.
    initial begin : stimulus
        string s;
        logic [7:0] c;
        int base_writes;
        axi_aresetn  = 1'b0;
        s_char_valid = 1'b0;
        s_char_data  = 8'h00;
        #1;
        chk("init_ready", 32'(s_char_ready), 32'h1);
        chk("init_busy", 32'(busy), 32'h0);
        chk("init_cursor", 32'(cursor), 32'h0);
        chk("init_awvalid", 32'(axi.awvalid), 32'h0);
        chk("init_resp_err", 32'(resp_err), 32'h0);
        #22 axi_aresetn = 1'b1;

        // Single character with both readys tied high.
        mode = 0;
        send_char(8'h41);
        wait_check("char_A");

        // Five characters, wready three cycles behind awready.
        do_reset();
        mode = 2;
        s = "HELLO";
        for (int i = 0; i < 5; i++) begin
            send_char(s[i]);
            wait_check("late_w");
        end

        // Fill row 0, print in the last column, then line feed.
        do_reset();
        mode = 1;
        for (int i = 0; i < 79; i++) begin
            send_char(rand_print());
            wait_check("row0_fill");
        end
        send_char(8'h78);
        wait_check("col79");
        send_char(8'h0A);
        wait_check("lf_row2");

        // Line feeds wrapping past the bottom row, ending on row 29.
        for (int i = 0; i < 57; i++) begin
            send_char(8'h0A);
            wait_check("lf_many");
        end
        for (int i = 0; i < 79; i++) begin
            send_char(rand_print());
            wait_check("last_row");
        end
        chk("cursor_2399", 32'(cursor), 32'd2399);
        bresp_sel = 2'b10;
        send_char(8'h7A);
        wait_check("last_cell");
        chk("wrap_zero", 32'(cursor), 32'd0);
        bresp_sel = 2'b00;
        send_char(8'h79);
        wait_check("err_sticky");
        chk("resp_err_sticky", 32'(resp_err), 32'h1);

        // Random mix of characters with random ready timing.
        for (int i = 0; i < 150; i++) begin
            c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) c = 8'h0A;
            else if ($urandom_range(0, 9) == 0) c = 8'h0D;
`ifdef HDMI_CONSOLE_CLEAR_EN
            if (c == 8'h0C) c = 8'h20;
`endif
            send_char(c);
            wait_check("random");
        end

`ifdef HDMI_CONSOLE_CLEAR_EN
        // Clear screen.
        base_writes = writes_seen;
        send_char(8'h0C);
        wait_check("clear");
        chk("clear_writes", 32'(writes_seen - base_writes), 32'(NCELL / 4));
        chk("clear_busy", 32'(busy), 32'h0);
`else
        base_writes = writes_seen;
        send_char(8'h0C);
        wait_check("ff_print");
        chk("ff_writes", 32'(writes_seen - base_writes), 32'h1);
`endif

        // Reset while stalled in XFER: the write must never complete.
        mode = 3;
        send_char(8'h51);
        repeat (2) @(negedge clk);
        chk("stall_awvalid", 32'(axi.awvalid), 32'h1);
        do_reset();
        mode = 0;
        repeat (10) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_cursor", 32'(cursor), 32'h0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
